text_banner_gen: RTL

- Parametrised successor to the fixed-logo text generator.
- Draws a writable string of N_CHARS glyphs at a parameterised pixel origin and power-of-two zoom, using the shared 128x16x8 font ROM (1-cycle synchronous read).
- Adds a register-loaded foreground colour, an optional background fill box, and frame-synchronous blinking.
- Sits between the VGA sync/pixel counters and the RGB output mux; its outputs are aligned 2 cycles behind pix_x/pix_y.

---
 rtl/text_banner_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/text_banner_gen.sv
// Zoomed text-string overlay over the VGA pixel stream, fed by a 1-cycle synchronous font ROM.
// Outputs are registered and trail pix_x/pix_y by exactly 2 clk; there is no backpressure.
module text_banner_gen #(
    parameter int          N_CHARS      = 4,
    parameter int          SCALE_LOG2   = 3,
    parameter int          X0           = 192,
    parameter int          Y0           = 256,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [2:0]  BG_RGB       = 3'b000,
    localparam int         IW           = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    input  logic          frame_tick,
    input  logic          color_wr,
    input  logic [2:0]    color_sel,
    input  logic          char_wr,
    input  logic [IW-1:0] char_idx,
    input  logic [6:0]    char_code,
    input  logic          blink_en,
    input  logic          bg_fill,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    font_word,
    output logic          text_on,
    output logic [2:0]    text_rgb
);

    localparam int CELL_W = 8 << SCALE_LOG2;
    localparam int CELL_H = 16 << SCALE_LOG2;
    localparam int BOX_W  = N_CHARS * CELL_W;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [6:0]    buf_q [N_CHARS];
    logic [6:0]    buf_d [N_CHARS];
    logic [2:0]    fg_q, fg_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          visible_q, visible_d;
    logic          v1_q, v1_d;
    logic          in_box_d1_q, in_box_d1_d;
    logic [2:0]    bit_d1_q, bit_d1_d;
    logic          text_on_q, text_on_d;
    logic [2:0]    text_rgb_q, text_rgb_d;

    logic [11:0]   px, py;
    logic [10:0]   dx, dy, ci_full;
    logic [IW-1:0] ci;
    logic [3:0]    row;
    logic          in_box;
    logic [6:0]    code;
    logic          glyph;
    logic          unused_bits;

    // Stage 0: banner-relative geometry and ROM address
    always_comb begin
        px      = {2'b00, pix_x};
        py      = {2'b00, pix_y};
        dx      = 11'({1'b0, pix_x} - 11'(X0));
        dy      = 11'({1'b0, pix_y} - 11'(Y0));
        in_box  = (px >= 12'(X0)) && (px < 12'(X0 + BOX_W)) &&
                  (py >= 12'(Y0)) && (py < 12'(Y0 + CELL_H));
        ci_full = dx >> (3 + SCALE_LOG2);
        ci      = ci_full[IW-1:0];
        row     = dy[SCALE_LOG2+3:SCALE_LOG2];
        code    = in_box ? buf_q[ci] : 7'h00;
        rom_addr = {code, row};
    end

    assign unused_bits = ^{dy, ci_full};

    always_comb begin
        buf_d = buf_q;
        if (char_wr && (32'(char_idx) < N_CHARS))
            buf_d[char_idx] = char_code;

        fg_d = color_wr ? color_sel : fg_q;

        cnt_d     = cnt_q;
        visible_d = visible_q;
        if (!blink_en) begin
            cnt_d     = '0;
            visible_d = 1'b1;
        end else if (frame_tick) begin
            if (cnt_q == BW'(BLINK_FRAMES - 1)) begin
                cnt_d     = '0;
                visible_d = ~visible_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        v1_d        = 1'b1;
        in_box_d1_d = in_box;
        bit_d1_d    = dx[SCALE_LOG2+2:SCALE_LOG2];

        // MSB of the font row is the leftmost pixel
        glyph      = font_word[3'd7 - bit_d1_q];
        text_on_d  = 1'b0;
        text_rgb_d = 3'b000;
        if (v1_q && in_box_d1_q && visible_q) begin
            if (glyph) begin
                text_on_d  = 1'b1;
                text_rgb_d = fg_q;
            end else if (bg_fill) begin
                text_on_d  = 1'b1;
                text_rgb_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CHARS; i++) buf_q[i] <= 7'h00;
            fg_q        <= 3'b010;
            cnt_q       <= '0;
            visible_q   <= 1'b1;
            v1_q        <= 1'b0;
            in_box_d1_q <= 1'b0;
            bit_d1_q    <= 3'd0;
            text_on_q   <= 1'b0;
            text_rgb_q  <= 3'b000;
        end else begin
            buf_q       <= buf_d;
            fg_q        <= fg_d;
            cnt_q       <= cnt_d;
            visible_q   <= visible_d;
            v1_q        <= v1_d;
            in_box_d1_q <= in_box_d1_d;
            bit_d1_q    <= bit_d1_d;
            text_on_q   <= text_on_d;
            text_rgb_q  <= text_rgb_d;
        end
    end

    assign text_on  = text_on_q;
    assign text_rgb = text_rgb_q;

endmodule
